i2c_slave_responder: RTL

- Synthesizable I2C target (responder) with a small internal byte register file.
- Sits on the far end of the bus driven by the I2C multi-bus controller.
- Gives the bench a real protocol partner and is reusable as a simple on-board peripheral.
- Runs on the system clock; oversamples SCL/SDA; no clock stretching.

---
 rtl/i2c_resp_pkg.sv | 20 ++
 rtl/i2c_bus_sync.sv | 43 ++++
 rtl/i2c_slave_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_resp_pkg.sv
// Shared types and bus constants for the I2C responder.
// FSM state encoding and open-drain drive levels.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;
  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge and START/STOP detection.
// All outputs are decoded from the synchronized value vs its last sample.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_ff1, scl_ff2, scl_prev;
  logic sda_ff1, sda_ff2, sda_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_ff1  <= 1'b1;
      scl_ff2  <= 1'b1;
      scl_prev <= 1'b1;
      sda_ff1  <= 1'b1;
      sda_ff2  <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_ff1  <= scl_i;
      scl_ff2  <= scl_ff1;
      scl_prev <= scl_ff2;
      sda_ff1  <= sda_i;
      sda_ff2  <= sda_ff1;
      sda_prev <= sda_ff2;
    end
  end

  // SDA edges only count as bus events while SCL stays high
  assign scl_rise  = scl_ff2 & ~scl_prev;
  assign scl_fall  = ~scl_ff2 & scl_prev;
  assign start_det = scl_ff2 & scl_prev & sda_prev & ~sda_ff2;
  assign stop_det  = scl_ff2 & scl_prev & ~sda_prev & sda_ff2;
  assign sda_s     = sda_ff2;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a small byte register file and auto-increment pointer.
// Oversamples SCL/SDA on clk_i; never stretches the clock.
module i2c_slave_responder
  import i2c_resp_pkg::*;
#(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
  parameter int MEM_DEPTH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic busy_o,
  output logic wr_stb_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o
);

  localparam int PW = $clog2(MEM_DEPTH);
  localparam int DW = I2C_DATA_WIDTH;
  localparam int AW = I2C_ADDR_WIDTH;

  logic scl_rise, scl_fall;
  logic start_det, stop_det;
  logic sda_s;

  i2c_bus_sync u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] shifter;
  logic [PW-1:0] ptr;
  logic [DW-1:0] mem [MEM_DEPTH];
  logic          first_byte;
  logic          rw;
  logic          rd_next;

  logic [DW-1:0] rx_byte;
  logic [PW-1:0] ptr_inc;

  assign rx_byte = {shifter[DW-2:0], sda_s};
  assign ptr_inc = ptr + 1'b1;
  assign scl_o   = 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shifter    <= '0;
      ptr        <= '0;
      first_byte <= 1'b0;
      rw         <= 1'b0;
      rd_next    <= 1'b0;
      sda_o      <= SDA_RELEASE;
      busy_o     <= 1'b0;
      wr_stb_o   <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      wr_stb_o <= 1'b0;
      unique case (1'b1)
        start_det: begin
          state   <= ADDR;
          bit_cnt <= '0;
          rd_next <= 1'b0;
          sda_o   <= SDA_RELEASE;
          busy_o  <= 1'b0;
        end
        stop_det: begin
          state   <= IDLE;
          bit_cnt <= '0;
          rd_next <= 1'b0;
          sda_o   <= SDA_RELEASE;
          busy_o  <= 1'b0;
        end
        default: begin
          unique case (state)
            IDLE: ;
            ADDR: begin
              if (scl_rise) begin
                shifter <= rx_byte;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                  bit_cnt <= '0;
                  if (rx_byte[DW-1 -: AW] == SLAVE_ADDR) begin
                    state  <= ADDR_ACK;
                    busy_o <= 1'b1;
                    rw     <= rx_byte[0];
                  end else begin
                    state <= IGNORE;
                  end
                end
              end
            end
            // first fall drives ACK, the fall after the 9th clock ends it
            ADDR_ACK: begin
              if (scl_fall) begin
                if (sda_o) begin
                  sda_o <= ACK;
                end else if (rw) begin
                  shifter <= mem[ptr];
                  sda_o   <= mem[ptr][DW-1];
                  bit_cnt <= '0;
                  state   <= RD_BYTE;
                end else begin
                  sda_o      <= SDA_RELEASE;
                  first_byte <= 1'b1;
                  bit_cnt    <= '0;
                  state      <= WR_BYTE;
                end
              end
            end
            WR_BYTE: begin
              if (scl_rise) begin
                shifter <= rx_byte;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                  bit_cnt <= '0;
                  state   <= WR_ACK;
                  if (first_byte) begin
                    ptr        <= rx_byte[PW-1:0];
                    first_byte <= 1'b0;
                  end else begin
                    mem[ptr]  <= rx_byte;
                    wr_stb_o  <= 1'b1;
                    wr_addr_o <= ptr;
                    wr_data_o <= rx_byte;
                    ptr       <= ptr_inc;
                  end
                end
              end
            end
            WR_ACK: begin
              if (scl_fall) begin
                if (sda_o) begin
                  sda_o <= ACK;
                end else begin
                  sda_o   <= SDA_RELEASE;
                  bit_cnt <= '0;
                  state   <= WR_BYTE;
                end
              end
            end
            RD_BYTE: begin
              if (scl_rise) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else if (scl_fall) begin
                if (bit_cnt == 4'd8) begin
                  sda_o   <= SDA_RELEASE;
                  rd_next <= 1'b0;
                  state   <= RD_ACK;
                end else begin
                  shifter <= {shifter[DW-2:0], 1'b0};
                  sda_o   <= shifter[DW-2];
                end
              end
            end
            // next byte is prefetched on the ACK rise, driven on the fall
            RD_ACK: begin
              if (scl_rise && !rd_next) begin
                if (sda_s == NACK) begin
                  state <= IGNORE;
                end else begin
                  ptr     <= ptr_inc;
                  shifter <= mem[ptr_inc];
                  rd_next <= 1'b1;
                end
              end else if (scl_fall && rd_next) begin
                sda_o   <= shifter[DW-1];
                bit_cnt <= '0;
                rd_next <= 1'b0;
                state   <= RD_BYTE;
              end
            end
            IGNORE: ;
            default: state <= IDLE;
          endcase
        end
      endcase
    end
  end

endmodule
